// File: rtl/bus_arbiter_pkg.sv
// Shared constants and types for the two-master peripheral-bridge arbiter.
// State encodings, master IDs and access-window bounds live here.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic MASTER_CPU = 1'b0;
    localparam logic MASTER_AUX = 1'b1;

    localparam int ACC_LAT_MIN = 1;
    localparam int ACC_LAT_MAX = 15;
    localparam int CNT_W       = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  byteen;
        logic [31:0] wdata;
        logic [31:0] pc;
    } bus_req_t;

    // Counter preload for an access window; out-of-range latencies are clamped.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        int l;
        l = lat;
        if (l < ACC_LAT_MIN) l = ACC_LAT_MIN;
        if (l > ACC_LAT_MAX) l = ACC_LAT_MAX;
        return CNT_W'(l - 1);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational 2-way round-robin chooser. When a lock owner is valid only
// the owner's request is eligible; the other master waits.
module bus_arbiter_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       lock_vld,
    input  logic       lock_id,
    output logic       grant_valid,
    output logic       grant_id
);

    logic [1:0] eligible;

    always_comb begin
        eligible = req;
        if (lock_vld)
            eligible = (lock_id == MASTER_AUX) ? (req & 2'b10) : (req & 2'b01);

        grant_valid = |eligible;
        case (eligible)
            2'b01:   grant_id = MASTER_CPU;
            2'b10:   grant_id = MASTER_AUX;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = MASTER_CPU;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the peripheral bridge port.
// Optional bus locking is enabled by defining BUS_ARB_LOCK_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int          ACCESS_LAT = 1,
    parameter logic [31:0] M1_PC      = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_byteen,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m0_pc,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_byteen,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
`ifdef BUS_ARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    output logic [31:0] s_addr,
    output logic [3:0]  s_byteen,
    output logic [31:0] s_wdata,
    output logic [31:0] s_pc,
    input  logic [31:0] s_rdata,
    output logic        busy
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(ACCESS_LAT);

    state_t           state;
    logic             last_grant;
    logic             owner;
    logic [CNT_W-1:0] cnt;

    bus_req_t m0_bus, m1_bus, sel_bus;
    logic     grant_valid, grant_id;
    logic     lock_vld, lock_id;

    assign m0_bus  = '{addr: m0_addr, byteen: m0_byteen, wdata: m0_wdata, pc: m0_pc};
    assign m1_bus  = '{addr: m1_addr, byteen: m1_byteen, wdata: m1_wdata, pc: M1_PC};
    assign sel_bus = (grant_id == MASTER_AUX) ? m1_bus : m0_bus;

    bus_arbiter_rr_pick u_rr_pick (
        .req         ({m1_req, m0_req}),
        .last_grant  (last_grant),
        .lock_vld    (lock_vld),
        .lock_id     (lock_id),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

`ifdef BUS_ARB_LOCK_EN
    logic sel_lock;
    assign sel_lock = (grant_id == MASTER_AUX) ? m1_lock : m0_lock;

    // Lock state follows the lock bit of every grant: while locked only the
    // owner can win, so an owner grant with lock=0 is the release point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_vld <= 1'b0;
            lock_id  <= MASTER_CPU;
        end else if (state == IDLE && grant_valid) begin
            lock_vld <= sel_lock;
            lock_id  <= grant_id;
        end
    end
`else
    assign lock_vld = 1'b0;
    assign lock_id  = MASTER_CPU;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= MASTER_AUX;
            owner      <= MASTER_CPU;
            cnt        <= '0;
            s_addr     <= '0;
            s_byteen   <= '0;
            s_wdata    <= '0;
            s_pc       <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        s_addr     <= sel_bus.addr;
                        s_byteen   <= sel_bus.byteen;
                        s_wdata    <= sel_bus.wdata;
                        s_pc       <= sel_bus.pc;
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= LAT_LOAD;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Write strobe is live for the first window cycle only.
                    s_byteen <= '0;
                    if (cnt == '0) begin
                        if (owner == MASTER_AUX) begin
                            m1_rdata <= s_rdata;
                            m1_ack   <= 1'b1;
                        end else begin
                            m0_rdata <= s_rdata;
                            m0_ack   <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: table of single transactions plus
// hand sequences for contention, reset abort and (optionally) bus lock.
module tb_bus_arbiter;

    localparam int          LAT   = 3;
    localparam logic [31:0] M1PC  = 32'hB000_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] s_addr, s_wdata, s_pc, s_rdata;
    logic [3:0]  s_byteen;
    logic        busy;
`ifdef BUS_ARB_LOCK_EN
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] mdl0 = '0, mdl1 = '0;

    always #5 clk = ~clk;

    bus_arbiter #(.ACCESS_LAT(LAT), .M1_PC(M1PC)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_byteen (m0_byteen),
        .m0_wdata  (m0_wdata),
        .m0_pc     (m0_pc),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_byteen (m1_byteen),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
`ifdef BUS_ARB_LOCK_EN
        .m0_lock   (m0_lock),
        .m1_lock   (m1_lock),
`endif
        .s_addr    (s_addr),
        .s_byteen  (s_byteen),
        .s_wdata   (s_wdata),
        .s_pc      (s_pc),
        .s_rdata   (s_rdata),
        .busy      (busy)
    );

    typedef struct {
        logic        r0;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] pc0;
        logic        r1;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] srd;
        logic        win;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction from IDLE; reqs are dropped once ack is seen.
    task automatic run_vec(input vec_t v);
        logic [31:0] ea, ewd, epc;
        logic [3:0]  ebe;
        ea  = v.win ? v.a1  : v.a0;
        ebe = v.win ? v.be1 : v.be0;
        ewd = v.win ? v.wd1 : v.wd0;
        epc = v.win ? M1PC  : v.pc0;
        m0_req = v.r0; m0_addr = v.a0; m0_byteen = v.be0; m0_wdata = v.wd0; m0_pc = v.pc0;
        m1_req = v.r1; m1_addr = v.a1; m1_byteen = v.be1; m1_wdata = v.wd1;
        s_rdata = v.srd;
        @(posedge clk); #1;
        chk("grant_busy", 32'(busy), 32'd1);
        chk("grant_addr", s_addr, ea);
        chk("grant_byteen", 32'(s_byteen), 32'(ebe));
        chk("grant_wdata", s_wdata, ewd);
        chk("grant_pc", s_pc, epc);
        for (int c = 1; c < LAT; c++) begin
            @(posedge clk); #1;
            chk("hold_addr", s_addr, ea);
            chk("hold_pc", s_pc, epc);
            chk("strobe_off", 32'(s_byteen), 32'd0);
            chk("early_ack", 32'({m1_ack, m0_ack}), 32'd0);
        end
        @(posedge clk); #1;
        chk("ack", 32'({m1_ack, m0_ack}), v.win ? 32'd2 : 32'd1);
        if (v.win) mdl1 = v.srd; else mdl0 = v.srd;
        chk("m0_rdata", m0_rdata, mdl0);
        chk("m1_rdata", m1_rdata, mdl1);
        chk("resp_byteen", 32'(s_byteen), 32'd0);
        m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk); #1;
        chk("back_idle", 32'({busy, m1_ack, m0_ack}), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int acks_seen, cyc, last_cyc;
        logic [1:0] order[4];
        logic [1:0] a;
        int busy_cnt;

        //         r0  a0            be0   wd0           pc0           r1  a1            be1   wd1           srd           win
        vecs[0] = '{1, 32'h0000_0010, 4'h0, 32'h0,        32'h0000_0100, 0, 32'h0,        4'h0, 32'h0,        32'hDEAD_BEEF, 0};
        vecs[1] = '{0, 32'h0,         4'h0, 32'h0,        32'h0,         1, 32'h0000_7F00, 4'hF, 32'h1234_5678, 32'h5555_AAAA, 1};
        vecs[2] = '{1, 32'h0000_0020, 4'h0, 32'h0,        32'h0000_0104, 1, 32'h0000_0030, 4'h0, 32'h0,        32'h0000_0001, 0};
        vecs[3] = '{1, 32'h0000_0020, 4'h3, 32'hA5A5_0000, 32'h0000_0108, 1, 32'h0000_0034, 4'h0, 32'h0,        32'h0000_0002, 1};
        vecs[4] = '{1, 32'h0000_0024, 4'h0, 32'h0,        32'h0000_010C, 1, 32'h0000_0038, 4'hC, 32'hFFFF_0000, 32'h0000_0003, 0};
        vecs[5] = '{0, 32'h0,         4'h0, 32'h0,        32'h0,         1, 32'h0000_003C, 4'h1, 32'h0000_00EE, 32'h0000_0004, 1};
        vecs[6] = '{1, 32'hFFFF_FFFC, 4'hF, 32'hCAFE_F00D, 32'h0000_0110, 0, 32'h0,        4'h0, 32'h0,        32'h0000_0005, 0};
        vecs[7] = '{1, 32'h0000_0040, 4'h0, 32'h0,        32'h0000_0114, 1, 32'h0000_0044, 4'h0, 32'h0,        32'h0000_0006, 1};

        reset = 1'b1;
        m0_req = 0; m0_addr = 0; m0_byteen = 0; m0_wdata = 0; m0_pc = 0;
        m1_req = 0; m1_addr = 0; m1_byteen = 0; m1_wdata = 0; s_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
        chk("rst_addr", s_addr, 32'd0);
        chk("rst_byteen", 32'(s_byteen), 32'd0);
        chk("rst_wdata", s_wdata, 32'd0);
        chk("rst_pc", s_pc, 32'd0);
        chk("rst_rdata0", m0_rdata, 32'd0);
        chk("rst_rdata1", m1_rdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_req", 32'({busy, s_byteen}), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Continuous contention: last winner was m1, so m0, m1, m0, m1.
        m0_req = 1; m0_addr = 32'h100; m0_byteen = 0; m0_pc = 32'h200;
        m1_req = 1; m1_addr = 32'h104; m1_byteen = 0; s_rdata = 32'h77;
        acks_seen = 0; cyc = 0; last_cyc = 0;
        while (acks_seen < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            a = {m1_ack, m0_ack};
            if (a == 2'b11) chk("dual_ack", 32'(a), 32'd1);
            if (a != 2'b00) begin
                order[acks_seen] = a;
                if (acks_seen > 0) chk("ack_spacing", 32'(cyc - last_cyc), 32'(LAT + 2));
                last_cyc = cyc;
                acks_seen++;
            end
        end
        m0_req = 0; m1_req = 0;
        chk("contention_count", 32'(acks_seen), 32'd4);
        if (acks_seen == 4) begin
            chk("rr_order0", 32'(order[0]), 32'd1);
            chk("rr_order1", 32'(order[1]), 32'd2);
            chk("rr_order2", 32'(order[2]), 32'd1);
            chk("rr_order3", 32'(order[3]), 32'd2);
        end
        mdl0 = 32'h77; mdl1 = 32'h77;
        @(posedge clk); #1;

        // Reset in the second ACCESS cycle of an m0 write: abort, no ack.
        m0_req = 1; m0_addr = 32'h44; m0_byteen = 4'h3; m0_wdata = 32'h1111_2222;
        @(posedge clk); #1;
        chk("pre_rst_strobe", 32'(s_byteen), 32'h3);
        m0_req = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_byteen", 32'(s_byteen), 32'd0);
        chk("abort_addr", s_addr, 32'd0);
        chk("abort_rdata0", m0_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mdl0 = '0; mdl1 = '0;
        busy_cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack || busy) busy_cnt++;
        end
        chk("abort_no_ack", 32'(busy_cnt), 32'd0);
        // last_grant back to m1 after reset, so m0 wins the tie.
        run_vec('{1, 32'h50, 4'h0, 32'h0, 32'h300, 1, 32'h54, 4'h0, 32'h0, 32'h0BAD_F00D, 0});

`ifdef BUS_ARB_LOCK_EN
        m0_lock = 1;
        run_vec('{1, 32'h60, 4'h0, 32'h0, 32'h304, 0, 32'h0, 4'h0, 32'h0, 32'h10, 0});
        m0_lock = 0;
        m1_req = 1; m1_addr = 32'h64; m1_byteen = 0;
        busy_cnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (busy || m1_ack) busy_cnt++;
        end
        chk("lock_starve", 32'(busy_cnt), 32'd0);
        run_vec('{1, 32'h68, 4'h0, 32'h0, 32'h308, 1, 32'h64, 4'h0, 32'h0, 32'h11, 0});
        run_vec('{0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 32'h64, 4'h0, 32'h0, 32'h12, 1});
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter in front of the processor-side port of the peripheral bridge (DM / TC0 / TC1 / interrupt-response window).
- Master 0 is the CPU data port (M stage). Master 1 is a secondary bus master (DMA / debug loader).
- Registers the winning request, drives it onto the bridge for a fixed access window, captures read data and returns a one-cycle ack to the winner.
- Arbitration is round-robin.

Parameters:
- ACCESS_LAT, 1, cycles the slave port is held per transaction (1..15).
- M1_PC, 32'h0000_0000, value driven on s_pc when master 1 owns the bus.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_addr  in  32  master 0 byte address
- m0_byteen  in  4  master 0 write byte enables; 0 = read
- m0_wdata  in  32  master 0 write data
- m0_pc  in  32  PC of the instruction issuing the access
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  32  read data, valid while m0_ack
- m1_req, m1_addr, m1_byteen, m1_wdata, m1_ack, m1_rdata: same as master 0, no pc
- m0_lock, m1_lock  in  1  bus lock request; present only with BUS_ARB_LOCK_EN
- s_addr  out  32  to bridge p_addr
- s_byteen  out  4  to bridge p_byteen
- s_wdata  out  32  to bridge p_wdata
- s_pc  out  32  to bridge p_pc
- s_rdata  in  32  from bridge p_rdata (combinational read)
- busy  out  1  high when state != IDLE

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset values:
  - state IDLE
  - all acks 0
  - s_addr/s_wdata/s_pc 0, s_byteen 4'b0000
  - rdata registers 0
  - last_grant = 1 (master 0 wins the first tie)
  - access counter 0
- Reset mid-transaction: abort immediately. No ack is issued, and any pending write with byteen already asserted is dropped.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the master != last_grant.
  - On grant: latch addr/byteen/wdata/pc (M1_PC for master 1) into output registers, update last_grant, load counter = ACCESS_LAT-1, go to ACCESS.
  - No request: stay in IDLE; s_byteen stays 0.
- ACCESS:
  - s_addr/s_wdata/s_pc are held stable for all ACCESS_LAT cycles.
  - s_byteen equals the latched byteen in the first ACCESS cycle only, and is 0 afterwards (exactly one write strobe per transaction).
  - The counter decrements each cycle.
  - In the cycle the counter is 0: capture s_rdata into the winner's rdata register, go to RESP.
- RESP:
  - Winner's ack = 1 for exactly one cycle; its rdata is valid that cycle and held until the next capture.
  - s_byteen = 0.
  - Next state is IDLE.
- Latency: req sampled at edge k; ACCESS during cycles k+1..k+ACCESS_LAT; ack during cycle k+ACCESS_LAT+1. A new grant is possible at edge k+ACCESS_LAT+2.
- Master rules:
  - Payload must be stable from req rise until ack.
  - A req still high in the cycle after ack is treated as a new request.
- The losing master's ack stays 0; its request waits without loss.
- Both acks are never high together.

Optional Feature:
- Macro: BUS_ARB_LOCK_EN.
- With the macro:
  - mX_lock is sampled at grant.
  - If set, a lock owner is recorded. Subsequent IDLE arbitration considers only the owner's req; the other master waits even if the owner is idle.
  - An owner transaction granted with lock=0 is served and then releases the lock.
  - reset clears the lock.
- Without the macro: lock ports are absent and arbitration is pure round-robin.

Decomposition:
- Shared constants header Bus_Arb_Consts.v, containing:
  - state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - master IDs (MASTER_CPU=1'b0, MASTER_AUX=1'b1)
  - ACCESS_LAT bounds
- Sub-module rr_pick: combinational 2-way round-robin chooser; inputs req[1:0], last_grant (and lock owner); outputs grant_valid and grant_id.
- FSM, counter and data registers live in bus_arbiter.

Test Plan:
- Single read, ACCESS_LAT=1: m0 reads 32'h0000_0010, s_rdata=32'hDEAD_BEEF → m0_ack at the 3rd edge after req, m0_rdata=32'hDEAD_BEEF, s_byteen stays 0.
- Write strobe count, ACCESS_LAT=3: m1 writes 32'h1234_5678, byteen 4'hF, addr 32'h0000_7F00 → s_byteen=4'hF for exactly 1 cycle, s_pc=M1_PC, m1_ack 4 cycles after grant.
- Contention: both req continuously from reset → grants alternate m0, m1, m0, m1; never two acks in one cycle.
- Back-to-back: m0 holds req after ack → new grant exactly one IDLE cycle later; m1 is served first if it is also requesting.
- Reset mid-ACCESS (ACCESS_LAT=4, second cycle) → busy=0 and s_byteen=0 immediately, no ack, last_grant=1.
- BUS_ARB_LOCK_EN: m0 locks, m1 requests → m1 is starved until m0 issues an unlocked access; then m1 is granted next.
